// File: rtl/eth_tx_pfc_arb.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_pfc_arb
// Purpose  : Frame-atomic AXI-Stream arbiter in front of the 10G MAC TX
//            input. Shares tx_axis among PORTS traffic-class sources, honours
//            per-source PFC/LFC pause requests, and acknowledges each pause
//            once that source is quiescent. One-deep registered output stage.
// Ports    : aclk/aresetn        clock, asynchronous active-low reset
//            s_axis_*            PORTS packed source streams (port i = slice i)
//            m_axis_*            single stream towards the MAC
//            pause_req/pause_ack per-source pause handshake
//            cfg_enable          allow new grants
//            stat_busy           high while a frame is being transferred
//            stat_grant          current/last granted port (zero-extended)
//            stat_frame_cnt      forwarded frames, wraps modulo 2^16
// Revision : 1.0 - initial release
// ============================================================================
module eth_tx_pfc_arb #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_W     = 1,
  parameter int ARB_RR     = 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [PORTS*USER_W-1:0]     s_axis_tuser,
  input  logic [PORTS-1:0]            s_axis_tlast,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  output logic [PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic [USER_W-1:0]           m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  input  logic [PORTS-1:0]            pause_req,
  output logic [PORTS-1:0]            pause_ack,
  input  logic                        cfg_enable,
  output logic                        stat_busy,
  output logic [2:0]                  stat_grant,
  output logic [15:0]                 stat_frame_cnt
);

  localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [PORTS-1:0]        ack_q, ack_d;
  logic [15:0]             cnt_q, cnt_d;

  logic                    ovalid_q;
  logic [DATA_WIDTH-1:0]   odata_q;
  logic [KEEP_WIDTH-1:0]   okeep_q;
  logic [USER_W-1:0]       ouser_q;
  logic                    olast_q;

  logic [PORTS-1:0]        w_elig;
  logic                    w_win_found;
  logic [IDX_W-1:0]        w_win_idx;
  logic                    w_xfer;
  logic                    w_ready_g;
  logic                    w_accept;
  logic                    w_last;

  // Winner search: walk PORTS candidates starting at the RR pointer
  // (or at 0 for strict priority), wrapping, and take the first eligible.
  always_comb begin
    int cand;
    cand        = 0;
    w_elig      = s_axis_tvalid & ~pause_req & ~ack_q;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 0; k < PORTS; k++) begin
      cand = ((ARB_RR != 0) ? int'(ptr_q) : 0) + k;
      if (cand >= PORTS) cand = cand - PORTS;
      if (!w_win_found && w_elig[cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = IDX_W'(cand);
      end
    end
  end

  assign w_xfer    = (state_q == ST_XFER);
  // Output register can take a beat when empty or draining this cycle.
  assign w_ready_g = ~ovalid_q | m_axis_tready;
  assign w_accept  = w_xfer & s_axis_tvalid[grant_q] & w_ready_g;
  assign w_last    = w_accept & s_axis_tlast[grant_q];

  always_comb begin
    s_axis_tready = '0;
    if (w_xfer) s_axis_tready[grant_q] = w_ready_g;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    // A port mid-frame only acknowledges once its tlast beat is taken, so
    // the finishing cycle already counts as quiescent.
    for (int i = 0; i < PORTS; i++) begin
      ack_d[i] = pause_req[i] & ~(w_xfer && (grant_q == IDX_W'(i)) && !w_last);
    end
    case (state_q)
      ST_IDLE: begin
        if (cfg_enable && w_win_found) begin
          state_d = ST_XFER;
          grant_d = w_win_idx;
        end
      end
      ST_XFER: begin
        if (w_last) begin
          state_d = ST_IDLE;
          ptr_d   = (int'(grant_q) == PORTS - 1) ? '0 : grant_q + 1'b1;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output stage: data only changes on an accepted beat, so it stays stable
  // while the MAC stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      okeep_q  <= '0;
      ouser_q  <= '0;
      olast_q  <= 1'b0;
    end else if (w_accept) begin
      ovalid_q <= 1'b1;
      odata_q  <= s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
      okeep_q  <= s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
      ouser_q  <= s_axis_tuser[grant_q*USER_W +: USER_W];
      olast_q  <= s_axis_tlast[grant_q];
    end else if (m_axis_tready) begin
      ovalid_q <= 1'b0;
    end
  end

  assign m_axis_tvalid  = ovalid_q;
  assign m_axis_tdata   = odata_q;
  assign m_axis_tkeep   = okeep_q;
  assign m_axis_tuser   = ouser_q;
  assign m_axis_tlast   = olast_q;
  assign pause_ack      = ack_q;
  assign stat_busy      = w_xfer;
  assign stat_grant     = 3'(grant_q);
  assign stat_frame_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_pfc_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_pfc_arb
// Purpose  : Randomized self-checking bench. Two arbiters (round-robin and
//            strict priority) share MAC ready, pause and enable stimulus;
//            each has its own random frame sources. A cycle-level reference
//            model per instance predicts every observable output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_tx_pfc_arb;
  localparam int P  = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 1;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [P*DW-1:0] tdata  [2];
  logic [P*KW-1:0] tkeep  [2];
  logic [P*UW-1:0] tuser  [2];
  logic [P-1:0]    tlast  [2];
  logic [P-1:0]    tvalid [2];
  logic [P-1:0]    tready [2];
  logic [DW-1:0]   mdata  [2];
  logic [KW-1:0]   mkeep  [2];
  logic [UW-1:0]   muser  [2];
  logic            mlast  [2];
  logic            mvalid [2];
  logic [P-1:0]    pack   [2];
  logic            busy   [2];
  logic [2:0]      sgrant [2];
  logic [15:0]     scnt   [2];
  logic            mready;
  logic [P-1:0]    preq;
  logic            en;

  eth_tx_pfc_arb #(.PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_W(UW), .ARB_RR(1)) u_rr (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(tdata[0]), .s_axis_tkeep(tkeep[0]), .s_axis_tuser(tuser[0]),
    .s_axis_tlast(tlast[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
    .m_axis_tdata(mdata[0]), .m_axis_tkeep(mkeep[0]), .m_axis_tuser(muser[0]),
    .m_axis_tlast(mlast[0]), .m_axis_tvalid(mvalid[0]), .m_axis_tready(mready),
    .pause_req(preq), .pause_ack(pack[0]), .cfg_enable(en),
    .stat_busy(busy[0]), .stat_grant(sgrant[0]), .stat_frame_cnt(scnt[0])
  );

  eth_tx_pfc_arb #(.PORTS(P), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_W(UW), .ARB_RR(0)) u_sp (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(tdata[1]), .s_axis_tkeep(tkeep[1]), .s_axis_tuser(tuser[1]),
    .s_axis_tlast(tlast[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
    .m_axis_tdata(mdata[1]), .m_axis_tkeep(mkeep[1]), .m_axis_tuser(muser[1]),
    .m_axis_tlast(mlast[1]), .m_axis_tvalid(mvalid[1]), .m_axis_tready(mready),
    .pause_req(preq), .pause_ack(pack[1]), .cfg_enable(en),
    .stat_busy(busy[1]), .stat_grant(sgrant[1]), .stat_frame_cnt(scnt[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Source state: each port walks through frames of 1..4 beats; once a beat
  // is offered it is held until the model says it was taken.
  bit            s_vld [2][P];
  int            s_pos [2][P];
  int            s_len [2][P];
  int            s_fid [2][P];
  logic [DW-1:0] s_dat [2][P];
  logic [KW-1:0] s_kp  [2][P];
  logic [UW-1:0] s_us  [2][P];

  // Reference model: "is a frame in flight", which port owns it, the next
  // port to favour, the one-beat output slot, pause acks and frame count.
  bit            mb   [2];
  int            mg   [2];
  int            mptr [2];
  bit            mov  [2];
  logic [DW-1:0] mod  [2];
  logic [KW-1:0] mok  [2];
  logic [UW-1:0] mou  [2];
  bit            mol  [2];
  logic [P-1:0]  mack [2];
  int            mcnt [2];

  function automatic logic [P-1:0] exp_ready(input int d);
    logic [P-1:0] r;
    r = '0;
    if (mb[d] && (!mov[d] || mready)) r[mg[d]] = 1'b1;
    return r;
  endfunction

  function automatic bit src_last(input int d, input int i);
    return s_pos[d][i] == s_len[d][i] - 1;
  endfunction

  task automatic drive_inputs(input int pv, input int pr, input int pp, input int pe);
    mready = ($urandom_range(99) < pr);
    for (int i = 0; i < P; i++)
      if ($urandom_range(99) < pp) preq[i] = ~preq[i];
    en = ($urandom_range(99) < pe);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < P; i++) begin
        if (!s_vld[d][i] && ($urandom_range(99) < pv)) begin
          s_vld[d][i] = 1'b1;
          s_dat[d][i] = {8'(i), 16'(s_fid[d][i]), 8'(s_pos[d][i]), 32'($urandom)};
          s_kp[d][i]  = KW'($urandom);
          s_us[d][i]  = UW'($urandom);
        end
        tvalid[d][i]          = s_vld[d][i];
        tdata[d][i*DW +: DW]  = s_dat[d][i];
        tkeep[d][i*KW +: KW]  = s_kp[d][i];
        tuser[d][i*UW +: UW]  = s_us[d][i];
        tlast[d][i]           = src_last(d, i);
      end
    end
  endtask

  task automatic compare(input int d);
    string nm;
    nm = (d == 0) ? "rr" : "sp";
    chk({nm, ".s_tready"}, 64'(tready[d]), 64'(exp_ready(d)));
    chk({nm, ".m_tvalid"}, 64'(mvalid[d]), 64'(mov[d]));
    if (mov[d]) begin
      chk({nm, ".m_tdata"}, mdata[d], mod[d]);
      chk({nm, ".m_keep_user_last"}, 64'({mkeep[d], muser[d], mlast[d]}),
          64'({mok[d], mou[d], mol[d]}));
    end
    chk({nm, ".pause_ack"}, 64'(pack[d]), 64'(mack[d]));
    chk({nm, ".stat_busy"}, 64'(busy[d]), 64'(mb[d]));
    chk({nm, ".stat_grant"}, 64'(sgrant[d]), 64'(mg[d]));
    chk({nm, ".frame_cnt"}, 64'(scnt[d]), 64'(mcnt[d]));
  endtask

  task automatic model_step(input int d);
    logic [P-1:0] rdy, nack;
    bit acc, lst, found;
    int g, base, idx;
    rdy = exp_ready(d);
    g   = mg[d];
    acc = mb[d] && s_vld[d][g] && rdy[g];
    lst = acc && src_last(d, g);
    for (int i = 0; i < P; i++)
      nack[i] = preq[i] && !(mb[d] && g == i && !lst);
    if (acc) begin
      mov[d] = 1'b1; mod[d] = s_dat[d][g]; mok[d] = s_kp[d][g];
      mou[d] = s_us[d][g]; mol[d] = lst;
    end else if (mready) begin
      mov[d] = 1'b0;
    end
    if (mb[d]) begin
      if (lst) begin
        mb[d]   = 1'b0;
        mptr[d] = (g + 1) % P;
        mcnt[d] = (mcnt[d] + 1) % 65536;
      end
    end else if (en) begin
      found = 1'b0;
      base  = (d == 0) ? mptr[d] : 0;
      for (int k = 0; k < P; k++) begin
        idx = (base + k) % P;
        if (!found && s_vld[d][idx] && !preq[idx] && !mack[d][idx]) begin
          found = 1'b1;
          mb[d] = 1'b1;
          mg[d] = idx;
        end
      end
    end
    mack[d] = nack;
    if (acc) begin
      s_vld[d][g] = 1'b0;
      if (lst) begin
        s_pos[d][g] = 0;
        s_len[d][g] = 1 + $urandom_range(3);
        s_fid[d][g]++;
      end else begin
        s_pos[d][g]++;
      end
    end
  endtask

  // Asynchronous reset: outputs must clear at once, not at the next edge.
  // Release happens just after a rising edge so the model and DUT both see
  // their first active edge at the same time.
  task automatic do_reset();
    aresetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < P; i++) begin
        s_vld[d][i] = 1'b0;
        s_pos[d][i] = 0;
        s_len[d][i] = 1 + $urandom_range(3);
        tvalid[d][i] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst.m_tvalid", 64'(mvalid[d]), 64'd0);
      chk("rst.s_tready", 64'(tready[d]), 64'd0);
      chk("rst.m_data", 64'(mdata[d]), 64'd0);
      chk("rst.m_keep_user_last", 64'({mkeep[d], muser[d], mlast[d]}), 64'd0);
      chk("rst.pause_ack", 64'(pack[d]), 64'd0);
      chk("rst.stat_busy", 64'(busy[d]), 64'd0);
      chk("rst.stat_grant", 64'(sgrant[d]), 64'd0);
      chk("rst.frame_cnt", 64'(scnt[d]), 64'd0);
      mb[d] = 1'b0; mg[d] = 0; mptr[d] = 0; mov[d] = 1'b0;
      mod[d] = '0; mok[d] = '0; mou[d] = '0; mol[d] = 1'b0;
      mack[d] = '0; mcnt[d] = 0;
    end
    repeat (2) @(posedge clk);
    #2 aresetn = 1'b1;
  endtask

  task automatic run_phase(input int pv, input int pr, input int pp, input int pe, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      drive_inputs(pv, pr, pp, pe);
      #1;
      for (int d = 0; d < 2; d++) compare(d);
      for (int d = 0; d < 2; d++) model_step(d);
    end
  endtask

  initial begin
    aresetn = 1'b1;
    mready  = 1'b0;
    preq    = '0;
    en      = 1'b0;
    for (int d = 0; d < 2; d++) begin
      tdata[d] = '0; tkeep[d] = '0; tuser[d] = '0; tlast[d] = '0; tvalid[d] = '0;
      for (int i = 0; i < P; i++) begin
        s_fid[d][i] = 0;
        s_dat[d][i] = '0; s_kp[d][i] = '0; s_us[d][i] = '0;
      end
    end
    #1 do_reset();
    // Dense traffic, MAC always ready, no pauses.
    run_phase(90, 100, 0, 100, 300);
    @(negedge clk); #2 do_reset();
    // MAC backpressure.
    run_phase(70, 60, 0, 100, 400);
    @(negedge clk); #2 do_reset();
    // Pause requests toggling, occasional disable.
    run_phase(80, 80, 5, 90, 600);
    @(negedge clk); #2 do_reset();
    // Sparse traffic, heavy pause and enable churn.
    run_phase(50, 50, 10, 60, 600);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_tx_pfc_arb.md
Name: eth_tx_pfc_arb

Overview:
- Frame-atomic AXI-Stream arbiter that shares the 10G MAC TX AXI input (tx_axis_*) among PORTS traffic-class sources.
- Honours per-source pause requests driven from the PFC/LFC receive-side outputs (rx_pfc_req), and acknowledges each pause once the source is quiescent.
- Sits between the per-class TX queues and the MAC TX input, with a one-deep registered output stage.

Parameters:
- PORTS, 4, number of source inputs (2..8).
- DATA_WIDTH, 64, tdata width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_W, 1, tuser width.
- ARB_RR, 1, 1 = round-robin, 0 = strict priority (lowest index wins).

Ports:
- aclk  input  1  clock.
- aresetn  input  1  asynchronous active-low reset.
- s_axis_tdata  input  PORTS*DATA_WIDTH  source data, port i at slice i.
- s_axis_tkeep  input  PORTS*KEEP_WIDTH  source byte enables.
- s_axis_tuser  input  PORTS*USER_W  source user bits.
- s_axis_tlast  input  PORTS  source end of frame.
- s_axis_tvalid  input  PORTS  source valid.
- s_axis_tready  output  PORTS  source ready.
- m_axis_tdata  output  DATA_WIDTH  to MAC tx_axis_tdata.
- m_axis_tkeep  output  KEEP_WIDTH  to MAC tx_axis_tkeep.
- m_axis_tuser  output  USER_W  to MAC tx_axis_tuser.
- m_axis_tlast  output  1  to MAC tx_axis_tlast.
- m_axis_tvalid  output  1  to MAC tx_axis_tvalid.
- m_axis_tready  input  1  from MAC tx_axis_tready.
- pause_req  input  PORTS  per-source pause request (from rx_pfc_req).
- pause_ack  output  PORTS  per-source pause acknowledge.
- cfg_enable  input  1  allow new grants.
- stat_busy  output  1  high in XFER state.
- stat_grant  output  3  index of the current/last granted port.
- stat_frame_cnt  output  16  frames forwarded, wraps modulo 2^16.

Behaviour:
- Reset (aresetn low, asynchronous), all registers cleared:
  - m_axis_tvalid=0; m_axis data, keep, user and last = 0.
  - s_axis_tready=0, pause_ack=0.
  - stat_busy=0, stat_grant=0, stat_frame_cnt=0.
  - State = IDLE; round-robin pointer = 0.
- State machine, two states: IDLE and XFER.
- IDLE:
  - eligible = s_axis_tvalid & ~pause_req & ~pause_ack, sampled in the current cycle.
  - If cfg_enable=1 and eligible != 0, select a winner:
    - ARB_RR=1: first eligible index at or after the RR pointer, wrapping.
    - ARB_RR=0: lowest eligible index.
  - The grant is registered. Next cycle the state is XFER, stat_grant=winner and stat_busy=1.
  - In IDLE, s_axis_tready is 0 for all ports.
- XFER:
  - s_axis_tready[g] = (~m_axis_tvalid | m_axis_tready). All other ports see 0.
  - A beat is accepted when s_axis_tvalid[g] & s_axis_tready[g]. It is loaded into the output register and appears on m_axis one cycle later (latency 1).
  - m_axis_tvalid holds until m_axis_tready. Output data is stable while valid & ~ready.
  - Throughput is 1 beat/cycle when m_axis_tready is held high.
  - On an accepted beat with tlast=1:
    - Next state is IDLE.
    - RR pointer = (g+1) mod PORTS.
    - stat_frame_cnt increments.
  - Back-to-back frames therefore incur exactly one source-side idle cycle. The output register may still drain during that cycle.
- Frames are atomic:
  - pause_req or cfg_enable deasserting mid-frame does not truncate the frame. The granted port stays granted until tlast is accepted.
  - A frame with a single beat (tlast on the first beat) is legal.
- Pause handshake, per port i (registered):
  - pause_ack[i] rises 1 cycle after pause_req[i]=1, provided port i is not the port currently in XFER.
  - If port i is in XFER, pause_ack[i] rises 1 cycle after its tlast beat is accepted.
  - pause_ack[i] falls 1 cycle after pause_req[i]=0.
  - A port with pause_req or pause_ack high is never granted.
  - A pause_req rising in the same cycle as the IDLE decision excludes that port.
- cfg_enable=0: no new grants; an in-progress frame completes. pause_ack is unaffected.
- Ports with index >= PORTS are never granted. stat_grant is zero-extended.

Test Plan:
- Single port: port 0 sends a 3-beat frame, m_axis_tready=1 → m_axis shows the same 3 beats starting 2 cycles after the port 0 valid (arbitration cycle + output register), tlast on beat 3; stat_frame_cnt=1.
- Round-robin: ARB_RR=1, ports 0–3 continuously valid with 2-beat frames → grant order 0,1,2,3,0; stat_frame_cnt=5 after 5 frames; no frame interleaving.
- Strict priority: ARB_RR=0, ports 1 and 3 continuously valid → only port 1 is granted; port 3 is granted after port 1 drops tvalid.
- Pause mid-frame: pause_req[2] asserted on beat 2 of a 4-beat port 2 frame → all 4 beats forwarded; pause_ack[2] rises 1 cycle after the tlast beat is accepted; port 2 is not regranted until pause_req[2]=0 and pause_ack[2] has fallen.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a frame → m_axis data stable while stalled; s_axis_tready[g]=0 whenever m_axis_tvalid=1 and m_axis_tready=0; no beat lost or duplicated.
- Reset mid-frame: aresetn pulled low during beat 2 → m_axis_tvalid=0 and s_axis_tready=0 immediately; after release, state=IDLE, stat_frame_cnt=0, RR pointer=0 (port 0 wins the first tie).
